sequenciador_programa: RTL
==========================

Name: sequenciador_programa

Overview:
- Fetch/issue sequencer placed in front of the processor datapath.
- Reads 16-bit instruction words from a synchronous program ROM and presents each one on the processor's iin bus.
- Holds the processor's resetn low between instructions, so its cycle counter restarts at 0 for every instruction, and high for exactly the number of execute cycles the opcode needs.
- Provides start, single-step and halt control to the testbench or host.

Parameters:
- ADDR_W, 8, program counter and ROM address width.
- START_ADDR, 0, PC value loaded on start.
- CYC_ALU, 3, execute cycles for add/sub; must be 1..4, matching the 2-bit datapath counter.

Ports:
- clk  in  1  system clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins execution at START_ADDR.
- step_mode  in  1  1 = pause after every instruction.
- step  in  1  one-cycle pulse; releases the pause in step mode.
- rom_en  out  1  ROM read enable.
- rom_addr  out  ADDR_W  ROM address; data returns on the next cycle.
- rom_data  in  16  ROM read data.
- iin  out  16  instruction to the processor.
- proc_resetn  out  1  processor resetn; high only in EXEC.
- pc  out  ADDR_W  current program counter.
- busy  out  1  high in FETCH, LOAD, EXEC and PAUSE.
- halted  out  1  high in HALTED.

Behaviour:
- Reset is asynchronous, active-low. On reset: state=IDLE, pc=START_ADDR, ir=0, iin=0, rom_en=0, proc_resetn=0, busy=0, halted=0.
- Instruction fields: opcode=ir[15:13], rx=ir[12:10], ry=ir[9:7].
- Opcodes:
  - 000 mv, 1 execute cycle.
  - 001 mvi, 1 execute cycle.
  - 010 add, CYC_ALU execute cycles.
  - 011 sub, CYC_ALU execute cycles.
  - 100..110 treated as NOP, 1 execute cycle.
  - 111 HALT.
- IDLE: waits for start. On start: pc<=START_ADDR, go to FETCH.
- FETCH (1 cycle): rom_en=1, rom_addr=pc. Go to LOAD.
- LOAD (1 cycle): ir<=rom_data, iin<=rom_data.
  - If opcode=111, go to HALTED; pc is not incremented.
  - Otherwise cnt<=cycles(opcode)-1 and go to EXEC.
- EXEC: proc_resetn=1 and iin is held stable. cnt decrements every cycle.
  - When cnt=0 this is the last EXEC cycle: pc<=pc+1, wrapping from 2^ADDR_W-1 to 0.
  - Next state is PAUSE if step_mode=1, otherwise FETCH.
- PAUSE: proc_resetn=0. A step pulse moves to FETCH.
  - If step_mode is cleared while in PAUSE, go to FETCH on the next cycle.
- HALTED: halted=1, busy=0. A start pulse sets pc<=START_ADDR and goes to FETCH.
- start while busy=1 is ignored.
- step outside PAUSE is ignored.
- If step and step_mode=0 occur together in PAUSE, FETCH is taken exactly once.
- proc_resetn is registered and glitch-free. It goes 0→1 on the first EXEC cycle and 1→0 on the cycle after the last EXEC cycle.
- Throughput in free run: 2 + cycles(opcode) clocks per instruction (mv = 3 clocks, add = 5 clocks with CYC_ALU=3).
- Reset mid-EXEC: proc_resetn drops immediately (asynchronously), and the instruction is abandoned.
- rom_addr is held at its last value when rom_en=0.
- rom_data is sampled only in LOAD.

Decomposition:
- Shared include file isa_defs.vh:
  - Opcode constants OP_MV, OP_MVI, OP_ADD, OP_SUB, OP_HALT.
  - State encodings S_IDLE, S_FETCH, S_LOAD, S_EXEC, S_PAUSE, S_HALTED.
  - Field position constants.
- Sub-module decod_ciclos: combinational, opcode[2:0] -> cycle count[2:0] plus an is_halt flag. Reusable by the processor's control unit.

Test Plan:
- Reset then start, ROM[0]=0x2000 (mvi), ROM[1]=0xE000 (HALT) -> proc_resetn high for exactly 1 cycle with iin=0x2000; halted=1 at pc=1, busy=0.
- ROM[0]=0x4000 (add), CYC_ALU=3 -> proc_resetn high for 3 consecutive cycles; iin stable throughout; next rom_en pulse 5 clocks after the previous one; pc=1.
- step_mode=1 with 3 NOP words -> pause after each instruction; pc advances 0→1→2 only on each step pulse; step pulses issued during EXEC are ignored.
- ADDR_W=2, ROM all NOP with START_ADDR=3 -> pc sequence 3,0,1,2,3; no halt.
- Assert resetn low during the 2nd EXEC cycle of an add -> proc_resetn=0 in the same cycle; state IDLE and pc=START_ADDR after release; start pulses while busy cause no restart.
- Start pulse while in HALTED -> re-execution from START_ADDR; halted drops on the next clock.

Source files
------------

// File: rtl/sequenciador_programa_pkg.sv
// Shared ISA definitions for the program sequencer: opcodes, instruction
// field positions, sequencer state encoding and a field-extraction helper.
package sequenciador_programa_pkg;

  localparam int INSTR_W = 16;

  localparam logic [2:0] OP_MV   = 3'b000;
  localparam logic [2:0] OP_MVI  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_HALT = 3'b111;

  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 13;
  localparam int RX_MSB  = 12;
  localparam int RX_LSB  = 10;
  localparam int RY_MSB  = 9;
  localparam int RY_LSB  = 7;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_LOAD   = 3'd2,
    S_EXEC   = 3'd3,
    S_PAUSE  = 3'd4,
    S_HALTED = 3'd5
  } state_t;

  function automatic logic [2:0] opcode_of(input logic [INSTR_W-1:0] word);
    return word[OPC_MSB:OPC_LSB];
  endfunction

endpackage

// File: rtl/sequenciador_programa_decod_ciclos.sv
// Combinational opcode decoder: execute-cycle count and halt flag.
// Kept standalone so the processor control unit can reuse the same table.
module decod_ciclos
  import sequenciador_programa_pkg::*;
#(
  parameter int CYC_ALU = 3
) (
  input  logic [2:0] opcode,
  output logic [2:0] cycles,
  output logic       is_halt
);

  always_comb begin
    cycles  = 3'd1;
    is_halt = 1'b0;
    case (opcode)
      OP_ADD, OP_SUB: cycles = 3'(CYC_ALU);
      OP_HALT: begin
        cycles  = 3'd0;
        is_halt = 1'b1;
      end
      default: cycles = 3'd1;
    endcase
  end

endmodule

// File: rtl/sequenciador_programa.sv
// Fetch/issue sequencer: reads instructions from a synchronous ROM, presents
// them on iin and opens proc_resetn for exactly the opcode's execute cycles.
module sequenciador_programa
  import sequenciador_programa_pkg::*;
#(
  parameter int ADDR_W     = 8,
  parameter int START_ADDR = 0,
  parameter int CYC_ALU    = 3
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic              step_mode,
  input  logic              step,
  output logic              rom_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [15:0]       rom_data,
  output logic [15:0]       iin,
  output logic              proc_resetn,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              halted
);

  localparam logic [ADDR_W-1:0] START_PC = ADDR_W'(START_ADDR);

  state_t            state_reg;
  logic [ADDR_W-1:0] pc_reg;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] rom_addr_reg;
  logic [15:0]       ir_reg;
  logic [1:0]        cnt_reg;
  logic              rom_en_reg;
  logic              proc_resetn_reg;
  logic              busy_reg;
  logic              halted_reg;

  logic [2:0] load_opcode;
  logic [2:0] load_cycles;
  logic       load_is_halt;

  assign load_opcode = opcode_of(rom_data);
  assign pc_inc      = pc_reg + {{(ADDR_W-1){1'b0}}, 1'b1};

  decod_ciclos #(
    .CYC_ALU(CYC_ALU)
  ) u_decod_ciclos (
    .opcode (load_opcode),
    .cycles (load_cycles),
    .is_halt(load_is_halt)
  );

  // All outputs are registered alongside the state so proc_resetn never glitches.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg       <= S_IDLE;
      pc_reg          <= START_PC;
      ir_reg          <= '0;
      cnt_reg         <= '0;
      rom_en_reg      <= 1'b0;
      rom_addr_reg    <= '0;
      proc_resetn_reg <= 1'b0;
      busy_reg        <= 1'b0;
      halted_reg      <= 1'b0;
    end else begin
      rom_en_reg <= 1'b0;
      case (state_reg)
        S_IDLE, S_HALTED: begin
          if (start) begin
            pc_reg       <= START_PC;
            rom_en_reg   <= 1'b1;
            rom_addr_reg <= START_PC;
            busy_reg     <= 1'b1;
            halted_reg   <= 1'b0;
            state_reg    <= S_FETCH;
          end
        end
        S_FETCH: state_reg <= S_LOAD;
        S_LOAD: begin
          ir_reg <= rom_data;
          if (load_is_halt) begin
            busy_reg   <= 1'b0;
            halted_reg <= 1'b1;
            state_reg  <= S_HALTED;
          end else begin
            cnt_reg         <= 2'(load_cycles - 3'd1);
            proc_resetn_reg <= 1'b1;
            state_reg       <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (cnt_reg == 2'd0) begin
            pc_reg          <= pc_inc;
            proc_resetn_reg <= 1'b0;
            if (step_mode) begin
              state_reg <= S_PAUSE;
            end else begin
              rom_en_reg   <= 1'b1;
              rom_addr_reg <= pc_inc;
              state_reg    <= S_FETCH;
            end
          end else begin
            cnt_reg <= cnt_reg - 2'd1;
          end
        end
        S_PAUSE: begin
          // Clearing step_mode releases the pause just like a step pulse.
          if (step || !step_mode) begin
            rom_en_reg   <= 1'b1;
            rom_addr_reg <= pc_reg;
            state_reg    <= S_FETCH;
          end
        end
        default: begin
          busy_reg        <= 1'b0;
          proc_resetn_reg <= 1'b0;
          state_reg       <= S_IDLE;
        end
      endcase
    end
  end

  assign rom_en      = rom_en_reg;
  assign rom_addr    = rom_addr_reg;
  assign iin         = ir_reg;
  assign proc_resetn = proc_resetn_reg;
  assign pc          = pc_reg;
  assign busy        = busy_reg;
  assign halted      = halted_reg;

endmodule
